// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. It drops in between processor pipeline stages (IF/ID, ID/EX,
// EX/MEM, MEM/WB) in place of enable-only registers. It streams one word per
// cycle, absorbs backpressure without a combinational ready path, and inserts
// a bubble on flush.
//
// Build option:
//   PIPE_STAGE_STALL_CNT_EN - when defined, adds the stall_cnt output, a
//                             saturating count of cycles spent stalled
//                             (out_valid & !out_ready). When undefined, the
//                             port and the counter are absent and the
//                             handshake is the same.
//
// Parameters:
//   WIDTH    payload width in bits (>= 1)
//   RST_VAL  out_data value after reset
//   NOP_VAL  out_data value loaded on flush (bubble encoding)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream has data
//   in_ready   stage can accept data (registered state, masked by rst)
//   in_data    upstream payload
//   out_valid  stage holds valid data (registered state only)
//   out_ready  downstream accepts data
//   out_data   payload to downstream (main register)
//   flush      synchronous squash of all held entries
//   stall_cnt  [PIPE_STAGE_STALL_CNT_EN only] saturating stall-cycle count
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned           WIDTH   = 16,
    parameter logic [WIDTH-1:0]      RST_VAL = '0,
    parameter logic [WIDTH-1:0]      NOP_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Occupancy encoding. 2'b11 is unreachable and decodes back to EMPTY.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic in_fire;
    logic out_fire;

    // Both handshake outputs come straight from the state register; rst only
    // masks in_ready so nothing is accepted while reset is held.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL) & ~rst;
        out_data  = main_q;
    end

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush wins over every other event: any same-cycle in_fire is
            // dropped, any same-cycle out_fire simply counts as delivered.
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new word behind main.
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        // main keeps its value; it is qualified by out_valid.
                        state_d = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so only the drain case matters.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts stalled cycles regardless of upstream activity; saturates rather
    // than wrapping, and survives flush so long stalls stay visible.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned      W   = 16;
    localparam logic [W-1:0]     RST = 16'h0000;
    localparam logic [W-1:0]     NOP = 16'hF00D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         flush = 1'b0;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .WIDTH   (W),
        .RST_VAL (RST),
        .NOP_VAL (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    initial begin
        // Reset asserted between edges: outputs drop without a clock.
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  {16'b0, out_data},  {16'b0, RST});
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back stream, 1-cycle latency, in_ready never drops.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(W'(i));
            #1;
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            step();
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_data",  {16'b0, out_data},  32'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", {31'b0, out_valid}, 32'd0);
        check("stream_drain_data",  {16'b0, out_data},  32'h0008);

        // Backpressure: fill to FULL, hold, then release in order.
        out_ready = 1'b0;
        send(16'h00A1);
        step();
        check("bp_a1_data",  {16'b0, out_data},  32'h00A1);
        check("bp_a1_ready", {31'b0, in_ready},  32'd1);
        send(16'h00A2);
        step();
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_full_data",  {16'b0, out_data}, 32'h00A1);
        send(16'h00A3);
        step();
        check("bp_hold_ready", {31'b0, in_ready},  32'd0);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_data",  {16'b0, out_data},  32'h00A1);
        out_ready = 1'b1;
        step();
        check("bp_rel_a2", {16'b0, out_data}, 32'h00A2);
        check("bp_rel_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("bp_rel_a3", {16'b0, out_data}, 32'h00A3);
        check("bp_rel_a3_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Simultaneous accept and deliver while ONE.
        send(16'h1111);
        step();
        send(16'h2222);
        step();
        check("sim_data",  {16'b0, out_data},  32'h2222);
        check("sim_valid", {31'b0, out_valid}, 32'd1);
        check("sim_ready", {31'b0, in_ready},  32'd1);
        in_valid = 1'b0;
        step();
        check("sim_empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL, with a word offered upstream.
        out_ready = 1'b0;
        send(16'h00B1);
        step();
        send(16'h00B2);
        step();
        check("fl_full_ready", {31'b0, in_ready}, 32'd0);
        send(16'h00B3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'b0, out_valid}, 32'd0);
        check("fl_data",  {16'b0, out_data},  {16'b0, NOP});
        check("fl_ready", {31'b0, in_ready},  32'd1);
        step();
        check("fl_b3_dropped", {31'b0, out_valid}, 32'd0);

        // Flush while ONE with a firing input: that input is discarded.
        send(16'h00B4);
        step();
        send(16'h00B5);
        flush = 1'b1;
        #1;
        check("fl1_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", {31'b0, out_valid}, 32'd0);
        check("fl1_data",  {16'b0, out_data},  {16'b0, NOP});
        step();
        check("fl1_b5_dropped", {31'b0, out_valid}, 32'd0);

        // Reset pulse mid-operation while FULL.
        send(16'h00B6);
        step();
        send(16'h00B7);
        step();
        in_valid = 1'b0;
        check("rm_full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rm_valid", {31'b0, out_valid}, 32'd0);
        check("rm_data",  {16'b0, out_data},  {16'b0, RST});
        #2 rst = 1'b0;
        out_ready = 1'b1;
        send(16'h00C0);
        #1;
        check("rm_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("rm_c0_data",  {16'b0, out_data},  32'h00C0);
        check("rm_c0_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("rm_no_stale", {31'b0, out_valid}, 32'd0);
        check("rm_no_stale_data", {16'b0, out_data}, 32'h00C0);

`ifdef PIPE_STAGE_STALL_CNT_EN
        rst = 1'b1;
        #1;
        check("sc_rst", {16'b0, stall_cnt}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        send(16'h00D0);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("sc_three", {16'b0, stall_cnt}, 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sc_flush_keeps", {16'b0, stall_cnt}, 32'd4);
        send(16'h00D1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check("sc_sat", {16'b0, stall_cnt}, 32'h0000FFFF);
        step();
        check("sc_sat_hold", {16'b0, stall_cnt}, 32'h0000FFFF);
        rst = 1'b1;
        #1;
        check("sc_clear", {16'b0, stall_cnt}, 32'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
